// File: rtl/mem_stage_if.sv
// Bus bundle for the memory-access stage: execute-side input, data-SRAM response,
// write-back handshake and hazard-status exports.
interface mem_stage_if;
  // Handshake: a transfer happens on a rising edge where the producer's valid
  // and the consumer's allowin are both high; valid never depends on allowin.
  logic        ex_to_mem_valid;
  logic [73:0] ex_reg;
  logic        mem_allowin;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        wb_allowin;
  logic        mem_to_wb_valid;
  logic [69:0] mem_reg;
  logic        mem_valid_o;
  logic        mem_gr_we_o;
  logic [4:0]  mem_dest_o;
  logic        mem_load_pending_o;

  modport slave (
    input  ex_to_mem_valid, ex_reg, data_sram_data_ok, data_sram_rdata, wb_allowin,
    output mem_allowin, mem_to_wb_valid, mem_reg, mem_valid_o, mem_gr_we_o,
           mem_dest_o, mem_load_pending_o
  );

  modport master (
    output ex_to_mem_valid, ex_reg, data_sram_data_ok, data_sram_rdata, wb_allowin,
    input  mem_allowin, mem_to_wb_valid, mem_reg, mem_valid_o, mem_gr_we_o,
           mem_dest_o, mem_load_pending_o
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds the execute bus, waits for load data,
// buffers it while write-back stalls, and aligns/extends it for write-back.
module mem_stage (
  input  logic      clk,
  input  logic      resetn,
  mem_stage_if.slave bus
);
  logic        mem_valid_q, mem_valid_d;
  logic [73:0] ex_reg_q, ex_reg_d;
  logic [31:0] rdata_buf_q, rdata_buf_d;
  logic        rdata_buf_valid_q, rdata_buf_valid_d;

  logic        res_from_mem;
  logic [2:0]  load_op;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;

  assign res_from_mem = ex_reg_q[73];
  assign load_op      = ex_reg_q[72:70];
  assign gr_we        = ex_reg_q[69];
  assign dest         = ex_reg_q[68:64];
  assign alu_result   = ex_reg_q[63:32];
  assign pc           = ex_reg_q[31:0];

  logic        mem_ready_go;
  logic        mem_leave;
  logic [31:0] raw_word;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign mem_ready_go = !res_from_mem || bus.data_sram_data_ok || rdata_buf_valid_q;
  assign mem_leave    = mem_valid_q && mem_ready_go && bus.wb_allowin;

  assign bus.mem_allowin        = !mem_valid_q || (mem_ready_go && bus.wb_allowin);
  assign bus.mem_to_wb_valid    = mem_valid_q && mem_ready_go;
  assign bus.mem_reg            = {gr_we, dest, final_result, pc};
  assign bus.mem_valid_o        = mem_valid_q;
  assign bus.mem_gr_we_o        = gr_we && mem_valid_q;
  assign bus.mem_dest_o         = dest;
  assign bus.mem_load_pending_o = mem_valid_q && res_from_mem && !mem_ready_go;

  always_comb begin
    raw_word = rdata_buf_valid_q ? rdata_buf_q : bus.data_sram_rdata;
    case (alu_result[1:0])
      2'd0:    load_byte = raw_word[7:0];
      2'd1:    load_byte = raw_word[15:8];
      2'd2:    load_byte = raw_word[23:16];
      default: load_byte = raw_word[31:24];
    endcase
    load_half = alu_result[1] ? raw_word[31:16] : raw_word[15:0];
    case (load_op)
      3'b001:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b011:  load_data = {24'd0, load_byte};
      3'b010:  load_data = {{16{load_half[15]}}, load_half};
      3'b100:  load_data = {16'd0, load_half};
      default: load_data = raw_word;
    endcase
    final_result = res_from_mem ? load_data : alu_result;
  end

  always_comb begin
    mem_valid_d       = mem_valid_q;
    ex_reg_d          = ex_reg_q;
    rdata_buf_d       = rdata_buf_q;
    rdata_buf_valid_d = rdata_buf_valid_q;
    if (bus.mem_allowin) mem_valid_d = bus.ex_to_mem_valid;
    if (bus.ex_to_mem_valid && bus.mem_allowin) ex_reg_d = bus.ex_reg;
    // Leaving clears the buffer and wins over a same-cycle capture.
    if (mem_leave) begin
      rdata_buf_valid_d = 1'b0;
    end else if (mem_valid_q && res_from_mem && bus.data_sram_data_ok &&
                 !rdata_buf_valid_q && !bus.wb_allowin) begin
      rdata_buf_d       = bus.data_sram_rdata;
      rdata_buf_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid_q       <= 1'b0;
      ex_reg_q          <= 74'd0;
      rdata_buf_q       <= 32'd0;
      rdata_buf_valid_q <= 1'b0;
    end else begin
      mem_valid_q       <= mem_valid_d;
      ex_reg_q          <= ex_reg_d;
      rdata_buf_q       <= rdata_buf_d;
      rdata_buf_valid_q <= rdata_buf_valid_d;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of load alignment vectors plus
// hand-written sequences for stalls, buffering, streaming and reset.
module tb_mem_stage;
  logic clk;
  logic resetn;
  mem_stage_if bus_if ();

  mem_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  int n_checks;
  int n_fails;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [73:0] act, input logic [73:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [73:0] mk_ex(input logic res, input logic [2:0] op, input logic we,
                                        input logic [4:0] dst, input logic [31:0] alu,
                                        input logic [31:0] pc);
    return {res, op, we, dst, alu, pc};
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [73:0] r, input logic ok,
                       input logic [31:0] rd, input logic wa);
    bus_if.ex_to_mem_valid   = v;
    bus_if.ex_reg            = r;
    bus_if.data_sram_data_ok = ok;
    bus_if.data_sram_rdata   = rd;
    bus_if.wb_allowin        = wa;
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"},   bus_if.mem_to_wb_valid,    1'b0);
    chk({tag, "_allowin"}, bus_if.mem_allowin,        1'b1);
    chk({tag, "_reg"},     bus_if.mem_reg,            70'd0);
    chk({tag, "_vo"},      bus_if.mem_valid_o,        1'b0);
    chk({tag, "_we"},      bus_if.mem_gr_we_o,        1'b0);
    chk({tag, "_dest"},    bus_if.mem_dest_o,         5'd0);
    chk({tag, "_pend"},    bus_if.mem_load_pending_o, 1'b0);
  endtask

  initial begin
    logic [73:0] r;
    logic [31:0] pc_a;
    logic [31:0] pc_b;
    int n_out;

    n_checks = 0;
    n_fails  = 0;
    vecs[0]  = '{3'b001, 32'h0000_1003, 32'h80FF_7F01, 32'hFFFF_FF80};
    vecs[1]  = '{3'b011, 32'h0000_1003, 32'h80FF_7F01, 32'h0000_0080};
    vecs[2]  = '{3'b010, 32'h0000_2002, 32'h8001_7FFF, 32'hFFFF_8001};
    vecs[3]  = '{3'b100, 32'h0000_2002, 32'h8001_7FFF, 32'h0000_8001};
    vecs[4]  = '{3'b000, 32'h0000_2002, 32'h8001_7FFF, 32'h8001_7FFF};
    vecs[5]  = '{3'b001, 32'h0000_3001, 32'h80FF_7F01, 32'h0000_007F};
    vecs[6]  = '{3'b001, 32'h0000_3000, 32'h80FF_7F01, 32'h0000_0001};
    vecs[7]  = '{3'b011, 32'h0000_3002, 32'h80FF_7F01, 32'h0000_00FF};
    vecs[8]  = '{3'b010, 32'h0000_4003, 32'h8001_7FFF, 32'hFFFF_8001};
    vecs[9]  = '{3'b010, 32'h0000_4000, 32'h8001_7FFF, 32'h0000_7FFF};
    vecs[10] = '{3'b100, 32'h0000_4001, 32'hFFFF_8000, 32'h0000_8000};
    vecs[11] = '{3'b111, 32'h0000_4001, 32'h1234_ABCD, 32'h1234_ABCD};

    resetn = 1'b0;
    drive(1'b0, 74'd0, 1'b0, 32'h0, 1'b1);
    repeat (3) cyc();
    #1;
    chk_reset_outputs("reset");
    resetn = 1'b1;

    // ALU op, one-cycle latency
    cyc();
    drive(1'b1, mk_ex(1'b0, 3'b000, 1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0000), 1'b0, 32'h0, 1'b1);
    chk("alu_allowin0", bus_if.mem_allowin, 1'b1);
    cyc();
    drive(1'b0, 74'd0, 1'b0, 32'h0, 1'b1);
    chk("alu_valid", bus_if.mem_to_wb_valid, 1'b1);
    chk("alu_reg", bus_if.mem_reg, {1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0000});
    chk("alu_allowin1", bus_if.mem_allowin, 1'b1);
    chk("alu_we", bus_if.mem_gr_we_o, 1'b1);
    chk("alu_dest", bus_if.mem_dest_o, 5'd5);
    cyc();
    #1;
    chk("alu_gone", bus_if.mem_valid_o, 1'b0);

    // Load alignment table: data_ok two cycles after accept
    for (int i = 0; i < 12; i++) begin
      r = mk_ex(1'b1, vecs[i].op, 1'b1, 5'(i + 1), vecs[i].alu, 32'h1C00_1000 + 32'(i * 4));
      cyc();
      drive(1'b1, r, 1'b0, 32'hDEAD_BEEF, 1'b1);
      cyc();
      drive(1'b0, 74'd0, 1'b0, 32'hDEAD_BEEF, 1'b1);
      chk($sformatf("ld%0d_pend1", i), bus_if.mem_load_pending_o, 1'b1);
      chk($sformatf("ld%0d_nv1", i), bus_if.mem_to_wb_valid, 1'b0);
      cyc();
      #1;
      chk($sformatf("ld%0d_pend2", i), bus_if.mem_load_pending_o, 1'b1);
      cyc();
      drive(1'b0, 74'd0, 1'b1, vecs[i].rdata, 1'b1);
      chk($sformatf("ld%0d_valid", i), bus_if.mem_to_wb_valid, 1'b1);
      chk($sformatf("ld%0d_reg", i), bus_if.mem_reg, {1'b1, 5'(i + 1), vecs[i].exp, r[31:0]});
      chk($sformatf("ld%0d_pend3", i), bus_if.mem_load_pending_o, 1'b0);
      cyc();
      drive(1'b0, 74'd0, 1'b0, 32'h5555_5555, 1'b1);
      chk($sformatf("ld%0d_gone", i), bus_if.mem_valid_o, 1'b0);
    end

    // Buffered load: data_ok while write-back stalls, rdata becomes garbage
    pc_a = 32'h1C00_2000;
    pc_b = 32'h1C00_2004;
    cyc();
    drive(1'b1, mk_ex(1'b1, 3'b000, 1'b1, 5'd9, 32'h0000_0100, pc_a), 1'b0, 32'h0, 1'b1);
    cyc();
    drive(1'b0, 74'd0, 1'b1, 32'hCAFE_BABE, 1'b0);
    chk("buf_valid0", bus_if.mem_to_wb_valid, 1'b1);
    chk("buf_allowin0", bus_if.mem_allowin, 1'b0);
    for (int k = 0; k < 2; k++) begin
      cyc();
      drive(1'b0, 74'd0, 1'b0, 32'h0BAD_0BAD + 32'(k), 1'b0);
      chk($sformatf("buf_hold%0d", k), bus_if.mem_reg, {1'b1, 5'd9, 32'hCAFE_BABE, pc_a});
      chk($sformatf("buf_v%0d", k), bus_if.mem_to_wb_valid, 1'b1);
      chk($sformatf("buf_al%0d", k), bus_if.mem_allowin, 1'b0);
    end
    cyc();
    drive(1'b1, mk_ex(1'b1, 3'b000, 1'b1, 5'd10, 32'h0000_0104, pc_b), 1'b0, 32'h0BAD_0BAD, 1'b1);
    chk("buf_leave_reg", bus_if.mem_reg, {1'b1, 5'd9, 32'hCAFE_BABE, pc_a});
    chk("buf_leave_allowin", bus_if.mem_allowin, 1'b1);
    cyc();
    drive(1'b0, 74'd0, 1'b0, 32'h0BAD_0BAD, 1'b1);
    chk("buf_cleared", bus_if.mem_to_wb_valid, 1'b0);
    chk("buf_next_pend", bus_if.mem_load_pending_o, 1'b1);
    chk("buf_next_pc", bus_if.mem_reg[31:0], pc_b);
    cyc();
    drive(1'b0, 74'd0, 1'b1, 32'h1111_2222, 1'b1);
    chk("buf_next_reg", bus_if.mem_reg, {1'b1, 5'd10, 32'h1111_2222, pc_b});
    cyc();
    drive(1'b0, 74'd0, 1'b0, 32'h0, 1'b1);
    chk("buf_next_gone", bus_if.mem_valid_o, 1'b0);

    // Ten back-to-back ALU ops, scoreboarded by PC
    n_out = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (i < 10) begin
        drive(1'b1, mk_ex(1'b0, 3'b000, 1'b1, 5'd3, 32'(i), 32'h1C00_0100 + 32'(i * 4)),
              1'b0, 32'h0, 1'b1);
        exp_q.push_back(32'h1C00_0100 + 32'(i * 4));
      end else begin
        drive(1'b0, 74'd0, 1'b0, 32'h0, 1'b1);
      end
      if (i >= 1 && i <= 10) begin
        chk($sformatf("b2b_valid%0d", i), bus_if.mem_to_wb_valid, 1'b1);
        chk($sformatf("b2b_allowin%0d", i), bus_if.mem_allowin, 1'b1);
      end
      if (bus_if.mem_to_wb_valid && bus_if.wb_allowin) begin
        if (exp_q.size() == 0) begin
          chk("b2b_extra", 1'b1, 1'b0);
        end else begin
          chk($sformatf("b2b_pc%0d", n_out), bus_if.mem_reg[31:0], exp_q.pop_front());
          n_out++;
        end
      end
    end
    chk("b2b_count", 32'(n_out), 32'd10);

    // Write-back stall holds the bus and blocks execute
    pc_a = 32'h1C00_3000;
    pc_b = 32'h1C00_3004;
    cyc();
    drive(1'b1, mk_ex(1'b0, 3'b000, 1'b0, 5'd7, 32'hAAAA_0000, pc_a), 1'b0, 32'h0, 1'b1);
    cyc();
    drive(1'b1, mk_ex(1'b0, 3'b000, 1'b1, 5'd8, 32'hBBBB_0000, pc_b), 1'b0, 32'h0, 1'b0);
    chk("stall_allowin", bus_if.mem_allowin, 1'b0);
    chk("stall_reg0", bus_if.mem_reg, {1'b0, 5'd7, 32'hAAAA_0000, pc_a});
    chk("stall_we0", bus_if.mem_gr_we_o, 1'b0);
    cyc();
    drive(1'b1, mk_ex(1'b0, 3'b000, 1'b1, 5'd8, 32'hBBBB_0000, pc_b), 1'b0, 32'h0, 1'b0);
    chk("stall_reg1", bus_if.mem_reg, {1'b0, 5'd7, 32'hAAAA_0000, pc_a});
    bus_if.wb_allowin = 1'b1;
    #1;
    chk("stall_release", bus_if.mem_allowin, 1'b1);
    cyc();
    drive(1'b0, 74'd0, 1'b0, 32'h0, 1'b1);
    chk("stall_next", bus_if.mem_reg, {1'b1, 5'd8, 32'hBBBB_0000, pc_b});
    cyc();

    // Reset in the middle of a load, then a stale data_ok
    drive(1'b1, mk_ex(1'b1, 3'b001, 1'b1, 5'd12, 32'h0000_0003, 32'h1C00_4000), 1'b0, 32'h0, 1'b1);
    cyc();
    drive(1'b0, 74'd0, 1'b0, 32'h0, 1'b1);
    chk("rst_pend_before", bus_if.mem_load_pending_o, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    chk_reset_outputs("rst_async");
    cyc();
    resetn = 1'b1;
    cyc();
    drive(1'b0, 74'd0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    chk_reset_outputs("rst_stale");
    cyc();
    drive(1'b0, 74'd0, 1'b0, 32'h0, 1'b1);
    chk_reset_outputs("rst_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipelined CPU, between the execute stage and the write-back stage. It registers the execute-stage bus, waits for the data-SRAM response on loads, and aligns and extends load data. It produces the 70-bit `{gr_we, dest, final_result, pc}` bus for write-back under the valid/allowin handshake. It also exports its destination and status for hazard detection in decode.

## Interface
- No parameters; all widths are fixed.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `resetn`  in  1  — asynchronous, active-low reset.
- `ex_to_mem_valid`  in  1  — the execute stage offers an instruction.
- `ex_reg`  in  74  — `{res_from_mem[73], load_op[72:70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}`.
- `mem_allowin`  out  1  — the stage can accept from execute this cycle.
- `data_sram_data_ok`  in  1  — one-cycle pulse; load data is valid on `data_sram_rdata`.
- `data_sram_rdata`  in  32  — raw word read from data SRAM.
- `wb_allowin`  in  1  — the write-back stage can accept.
- `mem_to_wb_valid`  out  1  — the bus on `mem_reg` is valid.
- `mem_reg`  out  70  — `{gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}`.
- `mem_valid_o`  out  1  — the stage holds a valid instruction.
- `mem_gr_we_o`  out  1  — `gr_we && mem_valid`.
- `mem_dest_o`  out  5  — destination register number.
- `mem_load_pending_o`  out  1  — `mem_valid && res_from_mem && !mem_ready_go`.

## Operation
**Stage registers:**
- `mem_valid`, `ex_reg_r[73:0]`, `rdata_buf[31:0]`, `rdata_buf_valid`.

**Ready and handshake:**
- `mem_ready_go = !res_from_mem || data_sram_data_ok || rdata_buf_valid`.
- `mem_allowin = !mem_valid || (mem_ready_go && wb_allowin)`.
- `mem_to_wb_valid = mem_valid && mem_ready_go`.

**Register updates:**
- When `mem_allowin`: `mem_valid <= ex_to_mem_valid`.
- When `ex_to_mem_valid && mem_allowin`: `ex_reg_r <= ex_reg`.

**Load buffer:**
- When `mem_valid && res_from_mem && data_sram_data_ok && !rdata_buf_valid && !wb_allowin`: `rdata_buf <= data_sram_rdata` and `rdata_buf_valid <= 1`.
- `rdata_buf_valid` clears on the cycle the instruction leaves the stage (`mem_to_wb_valid && wb_allowin`). Clear has priority over set.
- `data_sram_data_ok` is ignored when `!mem_valid`, when `!res_from_mem`, or when `rdata_buf_valid` is already set. Exactly one response per issued load is guaranteed by execute.

**Load data:**
- Raw word is `rdata_buf_valid ? rdata_buf : data_sram_rdata`.
- Byte offset is `alu_result[1:0]`.
- `load_op` decode:
  - 000 ld.w → the whole word.
  - 001 ld.b → the byte at the offset, sign-extended.
  - 011 ld.bu → the byte at the offset, zero-extended.
  - 010 ld.h → the halfword selected by `alu_result[1]` (bit 0 ignored), sign-extended.
  - 100 ld.hu → the same halfword, zero-extended.
  - 101–111 → treated as ld.w.

**Output bus:**
- `final_result = res_from_mem ? load_data : alu_result`.
- `mem_reg = {gr_we, dest, final_result, pc}`, driven from `ex_reg_r` plus the load path. It is purely combinational from registered state plus `data_sram_*`.

**Reset (`resetn` low, asynchronous):**
- `mem_valid`, `rdata_buf_valid`, `ex_reg_r` and `rdata_buf` are all cleared to 0.
- Resulting outputs: `mem_to_wb_valid=0`, `mem_allowin=1`, `mem_reg=0`, `mem_valid_o=0`, `mem_gr_we_o=0`, `mem_dest_o=0`, `mem_load_pending_o=0`.
- An in-flight load is dropped; a `data_ok` arriving after reset releases finds `mem_valid=0` and is ignored.

## Timing
- Non-load instruction: accepted at edge N, presented to write-back in cycle N..N+1, leaves at edge N+1 if `wb_allowin`. Latency is 1 cycle.
- Load: held until `data_sram_data_ok`. Leaves on the same edge that `data_ok` is high if `wb_allowin=1`; otherwise the data is buffered and the load leaves on a later edge without a second response.
- Back-to-back: with `wb_allowin=1` and no loads, the stage sustains one instruction per cycle; `mem_allowin` stays 1.
- Simultaneous leave and accept: the new `ex_reg` is captured and the buffer is cleared on the same edge.
- Combinational paths:
  - `data_sram_data_ok`/`data_sram_rdata` → `mem_to_wb_valid`, `mem_reg`, `mem_allowin`.
  - `wb_allowin` → `mem_allowin`.
- No combinational path exists from `ex_to_mem_valid` to any output.

## Test plan
- Reset, then an ALU op with `gr_we=1`, `dest=5`, `alu_result=0x1234_5678`, `pc=0x1C00_0000` and `wb_allowin=1` → next cycle `mem_to_wb_valid=1` and `mem_reg={1,5,0x12345678,0x1C000000}`; `mem_allowin=1` throughout.
- ld.b at `alu_result=0x...03` with `rdata=0x80FF_7F01` and `data_ok` 2 cycles after accept → `mem_load_pending_o=1` for 2 cycles, then `final_result=0xFFFF_FF80`. The same case with ld.bu → `0x0000_0080`.
- ld.h at offset 2 with `rdata=0x8001_7FFF` → `0xFFFF_8001`; ld.hu → `0x0000_8001`; ld.w → `0x8001_7FFF`.
- Load with `data_ok` while `wb_allowin=0` for 3 cycles, with `rdata` changing to garbage afterwards → `mem_to_wb_valid` stays 1 with the buffered data. The load leaves when `wb_allowin` rises; `rdata_buf_valid` is then 0.
- Ten back-to-back ALU ops with `wb_allowin=1` → ten consecutive `mem_to_wb_valid` cycles with in-order PCs. Toggling `wb_allowin` holds `mem_reg` stable and deasserts `mem_allowin`.
- Assert `resetn` low mid-load and release it, then pulse a stale `data_ok` → every output is at its reset value and no `mem_to_wb_valid` appears.
